// File: rtl/spi_slave_shift.sv
// SPI target-side shift engine: oversamples SCLK/SS_n/MOSI in the PCLK domain,
// receives 8-bit frames from MOSI and shifts a buffered byte out on MISO.
module spi_slave_shift #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_FILL   = 8'hFF
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       cpol_i,
  input  logic       cpha_i,
  input  logic       lsbfe_i,
  input  logic       sclk_i,
  input  logic       ss_n_i,
  input  logic       mosi_i,
  output logic       miso_o,
  output logic       miso_oe_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       underrun_o,
  output logic       frame_err_o
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t                 state, next_state;
  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic                   sclk_d, ss_d;
  logic                   sclk_s, ss_s, mosi_s;
  logic                   cpol_l, cpha_l, lsb_l;
  logic                   lead_edge, trail_edge, sample_edge, drive_edge;
  logic                   ss_fall, ss_rise;
  logic [2:0]             bit_cnt;
  logic                   buf_full, buf_wr;
  logic [7:0]             tx_buf, tx_shift, rx_shift, rx_next, load_byte;

  function automatic logic first_bit(input logic [7:0] b, input logic lsb);
    return lsb ? b[0] : b[7];
  endfunction

  function automatic logic [7:0] shift_in(input logic [7:0] b, input logic d,
                                          input logic lsb);
    return lsb ? {d, b[7:1]} : {b[6:0], d};
  endfunction

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Leading edge leaves the idle level, trailing edge returns to it.
  assign lead_edge   = (sclk_s != sclk_d) && (sclk_d == cpol_l);
  assign trail_edge  = (sclk_s != sclk_d) && (sclk_s == cpol_l);
  assign sample_edge = cpha_l ? trail_edge : lead_edge;
  assign drive_edge  = cpha_l ? lead_edge : trail_edge;
  assign ss_fall     = ss_d & ~ss_s;
  assign ss_rise     = ~ss_d & ss_s;

  assign tx_ready_o = ~buf_full;
  assign buf_wr     = tx_valid_i && (tx_ready_o || state == LOAD);
  assign load_byte  = buf_full ? tx_buf : IDLE_FILL;
  assign rx_next    = shift_in(rx_shift, mosi_s, lsb_l);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (ss_fall) next_state = LOAD;
      LOAD:    next_state = ss_rise ? IDLE : SHIFT;
      SHIFT: begin
        if (ss_rise)                             next_state = IDLE;
        else if (sample_edge && bit_cnt == 3'd7) next_state = LOAD;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      sclk_sync   <= '0;
      sclk_d      <= 1'b0;
      ss_sync     <= '1;
      ss_d        <= 1'b1;
      state       <= IDLE;
      cpol_l      <= 1'b0;
      cpha_l      <= 1'b0;
      lsb_l       <= 1'b0;
      bit_cnt     <= 3'd0;
      buf_full    <= 1'b0;
      miso_o      <= 1'b0;
      miso_oe_o   <= 1'b0;
      rx_data_o   <= 8'h00;
      rx_valid_o  <= 1'b0;
      underrun_o  <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
      sclk_d      <= sclk_s;
      ss_sync     <= {ss_sync[SYNC_STAGES-2:0], ss_n_i};
      ss_d        <= ss_s;
      state       <= next_state;
      rx_valid_o  <= 1'b0;
      underrun_o  <= 1'b0;
      frame_err_o <= 1'b0;
      miso_oe_o   <= (next_state != IDLE);
      if (buf_wr)              buf_full <= 1'b1;
      else if (state == LOAD)  buf_full <= 1'b0;
      case (state)
        IDLE: begin
          if (ss_fall) begin
            cpol_l <= cpol_i;
            cpha_l <= cpha_i;
            lsb_l  <= lsbfe_i;
          end
        end
        LOAD: begin
          bit_cnt    <= 3'd0;
          underrun_o <= ~buf_full;
          if (!cpha_l) miso_o <= first_bit(load_byte, lsb_l);
        end
        SHIFT: begin
          // SS_n rising takes priority over a coincident sample edge.
          if (ss_rise) begin
            if (bit_cnt != 3'd0) frame_err_o <= 1'b1;
          end else if (sample_edge) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_data_o  <= rx_next;
              rx_valid_o <= 1'b1;
            end
          end else if (drive_edge) begin
            // bit_cnt==0: cpha=1 presents the first bit; cpha=0 skips the frame-final trailing edge.
            if (bit_cnt != 3'd0)  miso_o <= lsb_l ? tx_shift[1] : tx_shift[6];
            else if (cpha_l)      miso_o <= first_bit(tx_shift, lsb_l);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
    if (buf_wr) tx_buf <= tx_data_i;
    case (state)
      LOAD:  tx_shift <= load_byte;
      SHIFT: begin
        if (!ss_rise) begin
          if (sample_edge)
            rx_shift <= rx_next;
          else if (drive_edge && bit_cnt != 3'd0)
            tx_shift <= lsb_l ? {1'b0, tx_shift[7:1]} : {tx_shift[6:0], 1'b0};
        end
      end
      default: ;
    endcase
  end

endmodule
